// File: rtl/dmem_loader_pkg.sv
// Shared state encoding and memory-layout helpers for dmem_loader.
package dmem_loader_pkg;

  typedef enum logic [2:0] {
    S_LOAD,
    S_RUN,
    S_RD_REQ,
    S_RD_WAIT,
    S_SEND,
    S_CHK,
    S_FIN
  } state_t;

  function automatic int calc_load_words(input int m, input int n, input int n2);
    return m * n + n * n2;
  endfunction

  // Result region sits directly after both operand matrices.
  function automatic int calc_res_base(input int m, input int n, input int n2);
    return calc_load_words(m, n, n2);
  endfunction

  function automatic int calc_res_words(input int m, input int n2);
    return m * n2;
  endfunction

  function automatic int calc_idx_w(input int m, input int n, input int n2);
    return $clog2(calc_load_words(m, n, n2) + 1);
  endfunction

endpackage

// File: rtl/dmem_stream_out.sv
// Output holding register for the result stream; load wins over pop so a
// new word can replace the one being accepted in the same cycle.
module dmem_stream_out #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  input  logic             pop,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_last  <= load_last;
    end else if (pop && out_valid) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dmem_loader.sv
// Loads operand matrices into CPU data memory, runs the CPU, then streams the
// result region back out. Optional trailing checksum word: DMEM_LOADER_CHECKSUM_EN.
module dmem_loader
  import dmem_loader_pkg::*;
#(
  parameter int M      = 100,
  parameter int N      = 50,
  parameter int N2     = 2,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 16
) (
  input  logic              CLOCK_50,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  output logic              in_ready,
  output logic              cpu_rst,
  input  logic              cpu_done,
  output logic              mem_own,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              finished
);

  localparam int LOAD_WORDS = calc_load_words(M, N, N2);
  localparam int RES_BASE   = calc_res_base(M, N, N2);
  localparam int RES_WORDS  = calc_res_words(M, N2);
  localparam int IDX_W      = calc_idx_w(M, N, N2);

  if ((longint'(RES_BASE) + longint'(RES_WORDS)) > (longint'(1) << ADDR_W)) begin : g_addr_range
    $error("dmem_loader: result region does not fit in ADDR_W address space");
  end

  state_t           state, state_next;
  logic [IDX_W-1:0] idx, idx_next;
  logic             accept, load_last_word, res_last, pop;
  logic             sr_load, sr_last;
  logic [WIDTH-1:0] sr_data;

  assign accept         = in_ready && in_valid;
  assign pop            = out_valid && out_ready;
  assign load_last_word = (idx == IDX_W'(LOAD_WORDS - 1));
  assign res_last       = (idx == IDX_W'(RES_WORDS - 1));

  // cpu_rst and finished are registered decodes of the upcoming state.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state    <= S_LOAD;
      idx      <= '0;
      cpu_rst  <= 1'b1;
      finished <= 1'b0;
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      cpu_rst  <= (state_next == S_LOAD);
      finished <= (state_next == S_FIN);
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      S_LOAD: begin
        if (accept) begin
          if (load_last_word) begin
            idx_next   = '0;
            state_next = S_RUN;
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end
      S_RUN:     if (cpu_done) state_next = S_RD_REQ;
      S_RD_REQ:  state_next = S_RD_WAIT;
      S_RD_WAIT: state_next = S_SEND;
      S_SEND: begin
        if (pop) begin
          if (res_last) begin
`ifdef DMEM_LOADER_CHECKSUM_EN
            state_next = S_CHK;
`else
            state_next = S_FIN;
`endif
          end else begin
            idx_next   = idx + 1'b1;
            state_next = S_RD_REQ;
          end
        end
      end
`ifdef DMEM_LOADER_CHECKSUM_EN
      S_CHK:     if (pop) state_next = S_FIN;
`endif
      S_FIN:     state_next = S_FIN;
      default:   state_next = S_LOAD;
    endcase
  end

  // Memory-side outputs are forced idle whenever rst is high.
  always_comb begin
    in_ready  = 1'b0;
    mem_own   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst) begin
      case (state)
        S_LOAD: begin
          in_ready = 1'b1;
          mem_own  = 1'b1;
          mem_addr = ADDR_W'(idx);
          if (in_valid) begin
            mem_we    = 1'b1;
            mem_wdata = in_data;
          end
        end
        S_RD_REQ, S_RD_WAIT: begin
          mem_own  = 1'b1;
          mem_addr = ADDR_W'(RES_BASE) + ADDR_W'(idx);
        end
        default: ;
      endcase
    end
  end

`ifdef DMEM_LOADER_CHECKSUM_EN
  logic [WIDTH-1:0] csum;

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      csum <= '0;
    end else if (state == S_SEND && pop) begin
      csum <= csum + out_data;
    end
  end

  // The checksum word replaces the final result word as it is accepted.
  assign sr_load = (state == S_RD_WAIT) || (state == S_SEND && pop && res_last);
  assign sr_data = (state == S_RD_WAIT) ? mem_rdata : csum + out_data;
  assign sr_last = (state != S_RD_WAIT);
`else
  assign sr_load = (state == S_RD_WAIT);
  assign sr_data = mem_rdata;
  assign sr_last = res_last;
`endif

  dmem_stream_out #(
    .WIDTH(WIDTH)
  ) u_stream_out (
    .clk       (CLOCK_50),
    .rst       (rst),
    .load      (sr_load),
    .load_data (sr_data),
    .load_last (sr_last),
    .pop       (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last)
  );

endmodule

// File: tb/tb_dmem_loader.sv
// Bench for dmem_loader with a 2x2x2 matrix product, a behavioural data memory
// and a stub CPU that fills the result region and raises cpu_done.
module tb_dmem_loader;

  localparam int M  = 2;
  localparam int N  = 2;
  localparam int N2 = 2;
  localparam int LW = M * N + N * N2;
  localparam int RB = LW;
  localparam int RW = M * N2;

  logic        CLOCK_50 = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready, cpu_rst, cpu_done, mem_own, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata, out_data;
  logic        out_valid, out_last, finished;
  logic        out_ready = 1'b0;

  int n_vectors = 0;
  int n_miscompares = 0;

  logic [31:0] load_vals [LW];
  logic [31:0] mem [0:255];
  int          wr_count, bad_wr, stub_cnt;
  logic        stub_done, stub_computed;
  logic        early_done = 1'b0;

  assign cpu_done = stub_done | early_done;

  always #5 CLOCK_50 = ~CLOCK_50;

  dmem_loader #(
    .M(M), .N(N), .N2(N2), .WIDTH(32), .ADDR_W(16)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .cpu_rst   (cpu_rst),
    .cpu_done  (cpu_done),
    .mem_own   (mem_own),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .finished  (finished)
  );

  // Synchronous-read data memory plus a stub CPU that multiplies in place.
  always @(posedge CLOCK_50) begin
    logic [31:0] acc;
    mem_rdata <= mem[mem_addr[7:0]];
    if (rst) begin
      wr_count <= 0;
      bad_wr   <= 0;
      for (int i = 0; i < RW; i++) mem[RB + i] <= 32'hDEAD_BEEF;
    end else if (mem_we) begin
      if (mem_own) begin
        mem[mem_addr[7:0]] <= mem_wdata;
        wr_count <= wr_count + 1;
      end else begin
        bad_wr <= bad_wr + 1;
      end
    end
    if (rst || cpu_rst) begin
      stub_cnt      <= 0;
      stub_done     <= 1'b0;
      stub_computed <= 1'b0;
    end else begin
      if (!stub_computed) begin
        for (int r = 0; r < M; r++)
          for (int c = 0; c < N2; c++) begin
            acc = '0;
            for (int k = 0; k < N; k++) acc += mem[r * N + k] * mem[M * N + k * N2 + c];
            mem[RB + r * N2 + c] <= acc;
          end
        stub_computed <= 1'b1;
      end
      if (stub_cnt < 20) stub_cnt <= stub_cnt + 1;
      else stub_done <= 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_vectors++;
    if (observed !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, observed, observed, expected, expected);
    end
  endtask

  task automatic resetDut();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    early_done = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    #1 rst = 1'b0;
  endtask

  task automatic setCounting();
    for (int i = 0; i < LW; i++) load_vals[i] = 32'(i + 1);
  endtask

  task automatic setRandom();
    int v;
    for (int i = 0; i < LW; i++) begin
      v = int'($urandom_range(0, 2000)) - 1000;
      load_vals[i] = v;
    end
  endtask

  // mode 0: back-to-back, 1: every other cycle, 2: random gaps.
  task automatic applyStimulus(input int mode, input int count);
    int k = 0;
    int cyc = 0;
    logic took;
    while (k < count && cyc < 200) begin
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 2 == 0);
        default: in_valid = ($urandom_range(0, 2) != 0);
      endcase
      in_data = load_vals[k];
      @(negedge CLOCK_50);
      checkOutput("load_in_ready", in_ready, 1);
      checkOutput("load_cpu_rst", cpu_rst, 1);
      checkOutput("load_mem_own", mem_own, 1);
      checkOutput("load_mem_we", mem_we, in_valid);
      if (in_valid) begin
        checkOutput("load_mem_addr", mem_addr, k);
        checkOutput("load_mem_wdata", mem_wdata, in_data);
      end
      took = in_valid && in_ready;
      @(posedge CLOCK_50);
      #1;
      if (took) k++;
      cyc++;
    end
    in_valid = 1'b0;
    if (k < count) checkOutput("load_timeout", k, count);
    if (count == LW) begin
      checkOutput("cpu_rst_fall", cpu_rst, 0);
      checkOutput("in_ready_off", in_ready, 0);
      if (mode == 0) begin
        repeat (3) begin
          in_valid = 1'b1;
          in_data = 32'd999;
          @(negedge CLOCK_50);
          checkOutput("excess_in_ready", in_ready, 0);
          checkOutput("excess_mem_we", mem_we, 0);
          @(posedge CLOCK_50);
          #1;
        end
        in_valid = 1'b0;
      end
    end
  endtask

  // stall 0: always ready, 1: hold off 5 cycles on the second word, 2: random.
  task automatic collectResults(input int stall);
    logic [31:0] exp_q[$];
    logic [31:0] acc, sum;
    int idx = 0, cyc = 0, stalls = 0, t0 = -1, t1 = -1;
    sum = '0;
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N2; c++) begin
        acc = '0;
        for (int k = 0; k < N; k++) acc += load_vals[r * N + k] * load_vals[M * N + k * N2 + c];
        exp_q.push_back(acc);
        sum += acc;
      end
`ifdef DMEM_LOADER_CHECKSUM_EN
    exp_q.push_back(sum);
`endif
    while (idx < exp_q.size() && cyc < 2000) begin
      case (stall)
        0:       out_ready = 1'b1;
        1:       out_ready = !(idx == 1 && stalls < 5);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      @(negedge CLOCK_50);
      if (t0 < 0 && !cpu_rst && cpu_done) t0 = cyc;
      checkOutput("run_cpu_rst", cpu_rst, 0);
      if (out_valid) begin
        if (t1 < 0) begin
          t1 = cyc;
          checkOutput("first_valid_latency", t1 - t0, 3);
        end
        checkOutput("out_data", out_data, exp_q[idx]);
        checkOutput("out_last", out_last, (idx == exp_q.size() - 1));
        if (out_ready) idx++;
        else if (stall == 1 && idx == 1) stalls++;
      end
      @(posedge CLOCK_50);
      #1;
      cyc++;
    end
    out_ready = 1'b0;
    if (idx < exp_q.size()) checkOutput("unload_timeout", idx, exp_q.size());
    if (stall == 1) checkOutput("stall_cycles", stalls, 5);
    repeat (2) @(negedge CLOCK_50);
    checkOutput("finished", finished, 1);
    checkOutput("fin_out_valid", out_valid, 0);
    checkOutput("fin_mem_own", mem_own, 0);
    checkOutput("fin_cpu_rst", cpu_rst, 0);
    checkOutput("write_count", wr_count, LW);
    checkOutput("unowned_writes", bad_wr, 0);
    for (int i = 0; i < LW; i++) checkOutput("mem_operand", mem[i], load_vals[i]);
    @(posedge CLOCK_50);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 32'h55;
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    checkOutput("rst_cpu_rst", cpu_rst, 1);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_mem_own", mem_own, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_last", out_last, 0);
    checkOutput("rst_finished", finished, 0);
    @(posedge CLOCK_50);
    #1 rst = 1'b0;
    in_valid = 1'b0;

    $display("[TB] counting operands, back-to-back");
    setCounting();
    applyStimulus(0, LW);
    collectResults(0);

    $display("[TB] counting operands, toggling valid, sink stall");
    resetDut();
    setCounting();
    applyStimulus(1, LW);
    collectResults(1);

    $display("[TB] reset after partial load");
    resetDut();
    setCounting();
    applyStimulus(0, 5);
    rst = 1'b1;
    in_valid = 1'b1;
    @(negedge CLOCK_50);
    checkOutput("midrst_in_ready", in_ready, 0);
    checkOutput("midrst_mem_we", mem_we, 0);
    @(posedge CLOCK_50);
    #1 rst = 1'b0;
    in_valid = 1'b0;
    @(negedge CLOCK_50);
    checkOutput("postrst_cpu_rst", cpu_rst, 1);
    checkOutput("postrst_in_ready", in_ready, 1);
    checkOutput("postrst_mem_addr", mem_addr, 0);
    @(posedge CLOCK_50);
    #1;
    applyStimulus(0, LW);
    collectResults(0);

    $display("[TB] cpu_done high before RUN");
    resetDut();
    early_done = 1'b1;
    setRandom();
    applyStimulus(2, LW);
    collectResults(2);

    for (int t = 0; t < 3; t++) begin
      $display("[TB] random run %0d", t);
      resetDut();
      setRandom();
      applyStimulus(2, LW);
      collectResults(2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_loader.md
# dmem_loader

Hardware host for the matrix-multiply RISCVCPU. Streams operand matrices from an external word source into CPU data memory while the CPU is held in reset, then releases the CPU. Waits for `done`, then reads the M×N2 result region back out of data memory as a word stream. It is the writer/extractor counterpart to the simulation-only result checker, so the same flow runs on the board without `$readmemb` or hierarchical memory access.

## Interface
Parameters:
- `M`, 100: rows in matrix1.
- `N`, 50: columns in matrix1 and rows in matrix2.
- `N2`, 2: columns in matrix2.
- `WIDTH`, 32: data word width.
- `ADDR_W`, 16: data memory word-address width.

Ports:
- `CLOCK_50` input 1: sole clock; everything on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `in_valid` input 1: operand word available.
- `in_data` input WIDTH: operand word, signed two's complement.
- `in_ready` output 1: loader accepts an operand word.
- `cpu_rst` output 1: reset to RISCVCPU.
- `cpu_done` input 1: CPU program-complete flag (level).
- `mem_own` output 1: loader owns the data-memory port; top level muxes on it.
- `mem_we` output 1: data-memory write enable.
- `mem_addr` output ADDR_W: data-memory word address.
- `mem_wdata` output WIDTH: data-memory write data.
- `mem_rdata` input WIDTH: data-memory read data, valid one cycle after `mem_addr`.
- `out_valid` output 1: result word valid.
- `out_data` output WIDTH: result word.
- `out_last` output 1: final word of the result stream.
- `out_ready` input 1: sink accepts the result word.
- `finished` output 1: sequence complete.

## Operation
- Constants:
  - LOAD_WORDS = M*N + N*N2.
  - RES_BASE = LOAD_WORDS.
  - RES_WORDS = M*N2.
  - Layout: matrix1 row-major at 0, matrix2 row-major at M*N, result row-major at RES_BASE.
- States: LOAD → RUN → RD_REQ → RD_WAIT → SEND → (CHK) → FIN.
- LOAD:
  - Outputs: `in_ready`=1, `mem_own`=1, `cpu_rst`=1.
  - On each `in_valid && in_ready`, same cycle: `mem_we`=1, `mem_addr`=idx, `mem_wdata`=`in_data`; then idx++.
  - On acceptance of word LOAD_WORDS-1: idx←0, go to RUN.
- RUN:
  - Outputs: `cpu_rst`=0, `mem_own`=0, `in_ready`=0.
  - `cpu_done` sampled high → go to RD_REQ.
  - `cpu_done` high on the first RUN cycle is honoured; no edge detection is required.
- RD_REQ: `mem_own`=1, `mem_addr`=RES_BASE+idx, `mem_we`=0; go to RD_WAIT.
- RD_WAIT: capture `mem_rdata` into the output register; go to SEND.
- SEND:
  - `out_valid`=1; `out_last`=1 when idx==RES_WORDS-1 and CHK is not compiled in.
  - On `out_ready`: if last → CHK/FIN, else idx++ and go to RD_REQ.
  - `out_data` and `out_last` stay stable while `out_valid && !out_ready`.
- FIN: `finished`=1, `mem_own`=0. `cpu_rst` stays 0 so the halted CPU's counters remain readable. Held until `rst`.
- `cpu_rst` stays 0 from RUN onward.
- Load-word count is a compile-time constant; excess `in_valid` after LOAD is ignored (`in_ready`=0).
- idx width: $clog2(LOAD_WORDS+1). Address adds are unsigned in ADDR_W. The elaboration error for RES_BASE+RES_WORDS > 2**ADDR_W is described under Structure.

## Timing
- Reset values (any cycle with `rst`=1):
  - State LOAD, idx 0.
  - `cpu_rst`=1, `in_ready`=0, `mem_we`=0.
  - `mem_own`=0, `mem_addr`=0, `mem_wdata`=0.
  - `out_valid`=0, `out_data`=0, `out_last`=0, `finished`=0.
- First cycle after `rst` falls: `in_ready`=1.
- `mem_we`, `mem_addr`, `mem_wdata`, `in_ready` in LOAD are combinational from state/handshake. All other outputs are registered.
- Load throughput: one word per cycle.
- `cpu_rst` falls on the edge that accepts the last word, so it is low in the next cycle.
- Unload: 3 cycles per word minimum, plus sink stall cycles.
- First `out_valid` appears 3 cycles after `cpu_done` is sampled.
- `rst` mid-operation, any state: abort the sequence. Next cycle is LOAD with idx 0 and `cpu_rst`=1. Partially written memory is not cleared.

## Configuration
- `DMEM_LOADER_CHECKSUM_EN` defined:
  - A WIDTH-bit wrapping sum of every result word accepted by the sink is accumulated.
  - After the last result word, state CHK presents the sum with `out_valid`=1, `out_last`=1.
  - Stream length is RES_WORDS+1.
- `DMEM_LOADER_CHECKSUM_EN` undefined: no accumulator, no CHK state; `out_last` is on result word RES_WORDS-1.

## Structure
- Package `dmem_loader_pkg` holds:
  - The state enum.
  - Functions computing LOAD_WORDS, RES_BASE, RES_WORDS, idx width.
- Address-range check: elaboration `$error` when RES_BASE+RES_WORDS > 2**ADDR_W.
- One sub-module: `dmem_stream_out`, the output register holding `out_valid`/`out_data`/`out_last`, with load and pop handshake.

## Test plan
Common setup: M=N=N2=2, stub CPU that computes the product in the memory model and raises `cpu_done` 20 cycles after `cpu_rst` falls.
- Stream 1..8 back-to-back → 8 writes at addr 0..7, one per cycle. `cpu_rst` low in the cycle after word 8. Stream out 19, 22, 43, 50; `out_last` on 50; `finished`=1.
- Same stimulus with `in_valid` toggling every other cycle → memory 0..7 = 1..8, result identical.
- `out_ready` low 5 cycles while 22 is presented → `out_data` holds 22, then the stream continues to 43.
- `rst` pulsed after 5 loaded words → `cpu_rst`=1 and `in_ready`=1 next cycle. Reload of 8 words writes from addr 0.
- `cpu_done` already high when RUN is entered → first `out_valid` 3 cycles later.
- `DMEM_LOADER_CHECKSUM_EN` defined → 5th word 134 with `out_last`; `out_last` absent on 50.
